vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator: the next generation of our fixed 640x480 sync block. It divides the system clock to a pixel tick and runs horizontal and vertical raster counters. It produces sync, blanking, coordinates and line/frame strobes, all registered and mutually aligned. It feeds the game engine and pixel pipeline. Every mode, sync polarity and clock ratio is selected by parameters.

## Interface
- `CLK_DIV`, 4, clk cycles per pixel tick (≥1)
- `CW`, 10, width of `x`/`y` and the internal counters; must satisfy `2^CW > H_TOTAL` and `2^CW > V_TOTAL`
- `H_DISP`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_DISP`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `H_POL`, 0, active level of `hsync` (0 = active-low)
- `V_POL`, 0, active level of `vsync`
- `FC_W`, 16, width of `frame_count` (macro build only)

Ports:
- `clk` in 1: system clock
- `rst` in 1: reset, synchronous, active-high
- `en` in 1: run enable; 0 freezes the divider and all counters
- `p_tick` out 1: pixel tick, one clk wide
- `x` out CW: current column
- `y` out CW: current line
- `hsync` out 1: horizontal sync, polarity set by `H_POL`
- `vsync` out 1: vertical sync, polarity set by `V_POL`
- `video_on` out 1: high when `x<H_DISP` and `y<V_DISP`
- `line_start` out 1: one-clk pulse when `x` becomes 0
- `frame_start` out 1: one-clk pulse when `x` and `y` both become 0
- `frame_count` out FC_W: completed-frame counter (macro build only)

## Operation
- Derived values: `H_TOTAL=H_DISP+H_FP+H_SYNC+H_BP`, `V_TOTAL=V_DISP+V_FP+V_SYNC+V_BP`.
- Divider `div` counts 0..CLK_DIV-1, wraps to 0, and advances only when `en=1`.
- `p_tick = en && (div==0)`, combinational. With `CLK_DIV=1`, `p_tick=en`.
- On `p_tick`, `h` increments. At `H_TOTAL-1`, `h` wraps to 0 and `v` increments. If `v` is at `V_TOTAL-1`, `v` also wraps to 0.
- Sync active regions:
  - `hsync` is active when `H_DISP+H_FP ≤ h < H_DISP+H_FP+H_SYNC`.
  - `vsync` is active when `V_DISP+V_FP ≤ v < V_DISP+V_FP+V_SYNC`.
- All outputs except `p_tick` are registers loaded on `p_tick` from the next counter values, so `x`, `y`, syncs and `video_on` always describe the same pixel (zero skew).
- `line_start` is set for exactly one clk in the cycle after a `p_tick` that wrapped `h`. `frame_start` is set the same way when `v` also wrapped. Both are cleared on every other clk.
- `en` falling mid-line: everything holds and `p_tick=0`. Strobes still self-clear after one clk. Resuming continues from the held position.
- Reset overrides `en`. A reset mid-frame restarts at (0,0) without emitting `frame_start`.

## Timing
- Reset values:
  - `div=0`, `x=0`, `y=0`
  - `hsync=~H_POL`, `vsync=~V_POL`
  - `video_on=1`
  - `line_start=0`, `frame_start=0`, `frame_count=0`
- First `p_tick` occurs in the first clk after `rst` deasserts, provided `en=1`. Ticks then repeat every `CLK_DIV` clks.
- Outputs change one clk after the `p_tick` edge, then hold for `CLK_DIV` clks.
- Line period is `H_TOTAL*CLK_DIV` clks; frame period is `H_TOTAL*V_TOTAL*CLK_DIV` clks. Defaults give 3200 and 1,680,000.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined:
  - `frame_count` exists.
  - It increments by 1 together with each `frame_start` assertion.
  - It wraps modulo `2^FC_W` and resets to 0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset check: hold `rst` for 3 clks with `en=1` → during reset, `x=0`, `y=0`, `hsync=1`, `vsync=1`, `video_on=1`, both strobes 0. After release, `p_tick` pulses every 4 clks.
- Horizontal timing, defaults → `video_on` falls when `x` goes 639→640. `hsync` is low for exactly 96 ticks (x=656..751). `line_start` pulses every 3200 clks.
- Vertical timing → `vsync` is low for lines 490–491 only. `frame_start` pulses once every 1,680,000 clks, coinciding with `line_start`.
- Enable freeze: drop `en` at x=100 for 50 clks → no `p_tick`, `x` stays 100, syncs unchanged. After `en` returns, `x` resumes at 101.
- Parameter variant: `CLK_DIV=1`, `H_POL=1`, small mode 8/1/2/1 x 4/1/1/1 → `p_tick` every clk. `hsync` is high exactly at x=9..10. Frame period is 12*7 = 84 clks.
- Macro build with `FC_W=2` → `frame_count` reads 0,1,2,3,0 across 4 frames. A `rst` mid-frame returns it to 0 with no `frame_start`.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: clock divider, h/v raster counters, sync,
// blanking, coordinates and line/frame strobes. Define VGA_TIMING_FRAME_CNT_EN for frame_count.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CW      = 10,
    parameter int unsigned H_DISP  = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_DISP  = 480,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33,
    parameter int unsigned H_POL   = 0,
    parameter int unsigned V_POL   = 0,
    parameter int unsigned FC_W    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          p_tick,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [FC_W-1:0] frame_count
`endif
);

    localparam int unsigned H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_DISP + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_DISP + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic        HS_ACT   = 1'(H_POL);
    localparam logic        VS_ACT   = 1'(V_POL);

    // Reject configurations whose counters could not hold a full line or frame.
    if ((CLK_DIV == 0) || (FC_W == 0) || ((2 ** CW) <= H_TOTAL) || ((2 ** CW) <= V_TOTAL)) begin : g_param_check
        $error("vga_timing_gen: illegal parameter set");
    end

    logic [DIV_W-1:0] div;
    logic             h_wrap;
    logic             v_wrap;
    logic [CW-1:0]    h_next;
    logic [CW-1:0]    v_next;
    logic             hs_region;
    logic             vs_region;
    logic             von_next;

    assign p_tick = en && (div == '0);

    // Next raster position; x/y are the counters themselves, so outputs stay aligned.
    always_comb begin
        h_wrap    = (x == CW'(H_TOTAL - 1));
        v_wrap    = h_wrap && (y == CW'(V_TOTAL - 1));
        h_next    = h_wrap ? '0 : x + CW'(1);
        v_next    = y;
        if (v_wrap) begin
            v_next = '0;
        end else if (h_wrap) begin
            v_next = y + CW'(1);
        end
        hs_region = (h_next >= CW'(HS_START)) && (h_next < CW'(HS_END));
        vs_region = (v_next >= CW'(VS_START)) && (v_next < CW'(VS_END));
        von_next  = (h_next < CW'(H_DISP)) && (v_next < CW'(V_DISP));
    end

    // Pixel-tick divider, frozen while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            div <= '0;
        end else if (en) begin
            div <= (div == DIV_W'(CLK_DIV - 1)) ? '0 : div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x           <= '0;
            y           <= '0;
            hsync       <= ~HS_ACT;
            vsync       <= ~VS_ACT;
            video_on    <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= p_tick && h_wrap;
            frame_start <= p_tick && v_wrap;
            if (p_tick) begin
                x        <= h_next;
                y        <= v_next;
                hsync    <= hs_region ? HS_ACT : ~HS_ACT;
                vsync    <= vs_region ? VS_ACT : ~VS_ACT;
                video_on <= von_next;
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Completed frames, stepping on the same edge that raises frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
        end else if (p_tick && v_wrap) begin
            frame_count <= frame_count + FC_W'(1);
        end
    end
`endif

endmodule
